// File: rtl/pixel_feeder_if.sv
// Pixel feeder bus: upstream pixel stream, line request from the window
// controller, and the registered pixel stream back to it.
interface pixel_feeder_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] s_data;
    logic                  s_valid;
    logic                  s_ready;
    logic                  i_en;
    logic                  i_req;
    logic [DATA_WIDTH-1:0] o_data;
    logic                  o_valid;
    logic                  o_sol;
    logic                  o_eol;
    logic                  o_eof;
    logic                  o_busy;

    // master is the feeder itself; slave is the surrounding source/controller
    modport master (
        input  s_data, s_valid, i_en, i_req,
        output s_ready, o_data, o_valid, o_sol, o_eol, o_eof, o_busy
    );
    modport slave (
        output s_data, s_valid, i_en, i_req,
        input  s_ready, o_data, o_valid, o_sol, o_eol, o_eof, o_busy
    );
endinterface

// File: rtl/pixel_feeder.sv
// Small input FIFO plus a line-granular sender: one granted request emits
// exactly LINE_LENGTH pixels, then a settle gap hides stale requests.
module pixel_feeder #(
    parameter int DATA_WIDTH  = 8,
    parameter int LINE_LENGTH = 640,
    parameter int LINE_NUM    = 480,
    parameter int FIFO_DEPTH  = 16,
    parameter int REQ_SETTLE  = 2
) (
    input  logic            CLK,
    input  logic            RST,
    pixel_feeder_if.master  bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = $clog2(LINE_LENGTH);
    localparam int LW = (LINE_NUM > 1) ? $clog2(LINE_NUM) : 1;
    localparam int GW = $clog2(REQ_SETTLE);

    localparam logic [AW:0]   FIFO_FULL = (AW+1)'(FIFO_DEPTH);
    localparam logic [PW-1:0] PIX_LAST  = PW'(LINE_LENGTH - 1);
    localparam logic [LW-1:0] LINE_LAST = LW'(LINE_NUM - 1);
    localparam logic [GW-1:0] GAP_LAST  = GW'(REQ_SETTLE - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SEND = 2'd1;
    localparam logic [1:0] GAP  = 2'd2;

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [AW:0]           count;
    logic                  full;
    logic                  empty;
    logic                  push;
    logic                  pop;

    logic [1:0]    state;
    logic [PW-1:0] pix_cnt;
    logic [LW-1:0] line_cnt;
    logic [GW-1:0] gap_cnt;

    logic [DATA_WIDTH-1:0] o_data_q;
    logic                  o_valid_q;
    logic                  o_sol_q;
    logic                  o_eol_q;
    logic                  o_eof_q;

    assign full  = (count == FIFO_FULL);
    assign empty = (count == '0);
    assign push  = bus.s_valid && !full;
    assign pop   = (state == SEND) && !empty;

    // storage is not reset; the pointers alone define what is valid
    always_ff @(posedge CLK) begin
        if (push) mem[wr_ptr] <= bus.s_data;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state    <= IDLE;
            pix_cnt  <= '0;
            line_cnt <= '0;
            gap_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.i_req && bus.i_en) begin
                        state   <= SEND;
                        pix_cnt <= '0;
                    end
                end
                SEND: begin
                    if (pop) begin
                        if (pix_cnt == PIX_LAST) begin
                            state    <= GAP;
                            gap_cnt  <= '0;
                            pix_cnt  <= '0;
                            line_cnt <= (line_cnt == LINE_LAST) ? '0 : line_cnt + 1'b1;
                        end else begin
                            pix_cnt <= pix_cnt + 1'b1;
                        end
                    end
                end
                GAP: begin
                    gap_cnt <= gap_cnt + 1'b1;
                    if (gap_cnt == GAP_LAST) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            o_data_q  <= '0;
            o_valid_q <= 1'b0;
            o_sol_q   <= 1'b0;
            o_eol_q   <= 1'b0;
            o_eof_q   <= 1'b0;
        end else begin
            o_valid_q <= pop;
            if (pop) o_data_q <= mem[rd_ptr];
            o_sol_q   <= pop && (pix_cnt == '0);
            o_eol_q   <= pop && (pix_cnt == PIX_LAST);
            o_eof_q   <= pop && (pix_cnt == PIX_LAST) && (line_cnt == LINE_LAST);
        end
    end

    assign bus.s_ready = !full;
    assign bus.o_data  = o_data_q;
    assign bus.o_valid = o_valid_q;
    assign bus.o_sol   = o_sol_q;
    assign bus.o_eol   = o_eol_q;
    assign bus.o_eof   = o_eof_q;
    assign bus.o_busy  = (state != IDLE);
endmodule

// File: tb/tb_pixel_feeder.sv
// Directed bench for pixel_feeder: 8-pixel lines, 3-line frames, 16-deep FIFO.
module tb_pixel_feeder;
    localparam int L = 8;

    logic CLK = 1'b0;
    logic RST = 1'b0;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_err = 0;

    typedef struct {
        logic [7:0] d;
        logic       sol;
        logic       eol;
        logic       eof;
        int         cyc;
    } pix_t;
    pix_t got[$];

    pixel_feeder_if #(.DATA_WIDTH(8)) bus ();

    pixel_feeder #(
        .DATA_WIDTH (8),
        .LINE_LENGTH(L),
        .LINE_NUM   (3),
        .FIFO_DEPTH (16),
        .REQ_SETTLE (2)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .bus(bus)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    always @(negedge CLK) begin
        if (RST && bus.o_valid)
            got.push_back('{bus.o_data, bus.o_sol, bus.o_eol, bus.o_eof, cyc});
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic fill(input int first, input int n);
        for (int i = 0; i < n; i++) begin
            bus.s_data  = 8'(first + i);
            bus.s_valid = 1'b1;
            tick();
        end
        bus.s_valid = 1'b0;
    endtask

    task automatic chk_line(input string tag, input int base, input int idx, input bit eof_exp);
        for (int i = 0; i < L; i++) begin
            if (idx + i < got.size()) begin
                chk($sformatf("%s_d%0d", tag, i),   32'(got[idx+i].d),   32'(8'(base + i)));
                chk($sformatf("%s_sol%0d", tag, i), 32'(got[idx+i].sol), 32'(i == 0));
                chk($sformatf("%s_eol%0d", tag, i), 32'(got[idx+i].eol), 32'(i == L-1));
                chk($sformatf("%s_eof%0d", tag, i), 32'(got[idx+i].eof), 32'(eof_exp && i == L-1));
            end
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_valid"}, 32'(bus.o_valid), 0);
        chk({tag, "_data"},  32'(bus.o_data),  0);
        chk({tag, "_sol"},   32'(bus.o_sol),   0);
        chk({tag, "_eol"},   32'(bus.o_eol),   0);
        chk({tag, "_eof"},   32'(bus.o_eof),   0);
        chk({tag, "_busy"},  32'(bus.o_busy),  0);
        chk({tag, "_ready"}, 32'(bus.s_ready), 1);
    endtask

    initial begin
        int nxt;
        bit seen;
        bus.s_data  = '0;
        bus.s_valid = 1'b0;
        bus.i_en    = 1'b0;
        bus.i_req   = 1'b0;

        // reset state
        tick(); tick();
        chk_idle_outputs("reset");
        RST = 1'b1;
        tick();

        // single line, FIFO pre-filled 0..15, 1-cycle request pulse
        fill(0, 15);
        chk("fill15_ready", 32'(bus.s_ready), 1);
        fill(15, 1);
        chk("fill16_ready", 32'(bus.s_ready), 0);
        bus.i_en = 1'b1;
        bus.i_req = 1'b1;
        tick();
        bus.i_req = 1'b0;
        repeat (20) tick();
        chk("l1_count", 32'(got.size()), L);
        chk_line("l1", 0, 0, 1'b0);
        chk("l1_busy", 32'(bus.o_busy), 0);
        chk("l1_ready", 32'(bus.s_ready), 1);

        // request dropped 2 cycles into the line: line still completes, no new line
        got.delete();
        bus.i_req = 1'b1;
        tick(); tick(); tick();
        bus.i_req = 1'b0;
        repeat (20) tick();
        chk("drop_count", 32'(got.size()), L);
        chk_line("drop", 8, 0, 1'b0);
        chk("drop_busy", 32'(bus.o_busy), 0);

        // stale request held through the settle gap; third line of the frame
        got.delete();
        fill(16, 16);
        chk("stale_full", 32'(bus.s_ready), 0);
        bus.i_req = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            tick();
            if (bus.o_valid && bus.o_eol) seen = 1'b1;
        end
        chk("stale_eol_seen", 32'(seen), 1);
        tick(); tick();
        bus.i_req = 1'b0;
        repeat (20) tick();
        chk("stale_count", 32'(got.size()), L);
        chk_line("stale", 16, 0, 1'b1);
        chk("stale_busy", 32'(bus.o_busy), 0);

        // continuous request over a whole frame, refilling as space opens
        got.delete();
        fill(32, 8);
        bus.i_req = 1'b1;
        nxt = 40;
        for (int k = 0; k < 150 && got.size() < 3*L; k++) begin
            if (got.size() >= 2*L + 1) bus.i_req = 1'b0;
            if (nxt < 48 && bus.s_ready) begin
                bus.s_data  = 8'(nxt);
                bus.s_valid = 1'b1;
                nxt++;
            end else begin
                bus.s_valid = 1'b0;
            end
            tick();
        end
        bus.s_valid = 1'b0;
        bus.i_req = 1'b0;
        repeat (20) tick();
        chk("frame_count", 32'(got.size()), 3*L);
        for (int j = 0; j < 3; j++)
            chk_line($sformatf("frame%0d", j), 24 + 8*j, 8*j, j == 2);
        if (got.size() >= 3*L) begin
            chk("frame_period01", 32'(got[8].cyc - got[0].cyc), L + 3);
            chk("frame_period12", 32'(got[16].cyc - got[8].cyc), L + 3);
        end

        // upstream bubbles: s_valid alternates, output strobes every other cycle
        got.delete();
        bus.i_req = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if (i == 2) bus.i_req = 1'b0;
            bus.s_valid = (i % 2 == 0);
            bus.s_data  = 8'(100 + i/2);
            tick();
        end
        bus.s_valid = 1'b0;
        repeat (20) tick();
        chk("bub_count", 32'(got.size()), L);
        chk_line("bub", 100, 0, 1'b0);
        if (got.size() >= L)
            chk("bub_span", 32'(got[L-1].cyc - got[0].cyc), 14);
        chk("bub_ready", 32'(bus.s_ready), 1);

        // asynchronous reset after 3 pixels of a line
        got.delete();
        fill(200, 16);
        bus.i_req = 1'b1;
        tick();
        bus.i_req = 1'b0;
        for (int k = 0; k < 40 && got.size() < 3; k++) tick();
        chk("rst_wait3", 32'(got.size() >= 3), 1);
        chk("rst_valid_before", 32'(bus.o_valid), 1);
        RST = 1'b0;
        #1;
        chk_idle_outputs("rst_async");
        tick(); tick();
        RST = 1'b1;
        tick();
        got.delete();
        fill(50, 8);
        bus.i_req = 1'b1;
        tick();
        bus.i_req = 1'b0;
        repeat (20) tick();
        chk("post_rst_count", 32'(got.size()), L);
        chk_line("post_rst", 50, 0, 1'b0);
        chk("post_rst_busy", 32'(bus.o_busy), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/pixel_feeder.md
# pixel_feeder

Upstream pixel source for the 3x3 window line-buffer controller. Accepts raw 8-bit pixels from the camera/DMA stream into a small FIFO. Answers the controller's line request (`i_req`) by emitting exactly one full line of `LINE_LENGTH` pixels per granted request, never a partial line. It also enforces a settle gap so that a stale request is never honoured.

## Interface
- `DATA_WIDTH`, 8: pixel width.
- `LINE_LENGTH`, 640: pixels per line; must be ≥ 2.
- `LINE_NUM`, 480: lines per frame.
- `FIFO_DEPTH`, 16: input FIFO entries; must be a power of 2, ≥ 2.
- `REQ_SETTLE`, 2: idle cycles after a line's last pop before `i_req` is sampled again; must be ≥ 2.
- `CLK`  in  1  clock.
- `RST`  in  1  reset, asynchronous, active-low.
- `s_data`  in  DATA_WIDTH  upstream pixel.
- `s_valid`  in  1  upstream pixel valid.
- `s_ready`  out  1  FIFO can accept; equals `!full`.
- `i_en`  in  1  feed enable. When low, no new line starts.
- `i_req`  in  1  line request from the window controller (its `o_req`).
- `o_data`  out  DATA_WIDTH  pixel to the controller (its `i_data`).
- `o_valid`  out  1  pixel strobe (the controller's `i_valid`).
- `o_sol`  out  1  high with the first pixel of each line.
- `o_eol`  out  1  high with the last pixel of each line.
- `o_eof`  out  1  high with the last pixel of line `LINE_NUM-1`.
- `o_busy`  out  1  FSM not in IDLE.

## Operation
- FIFO push: `s_valid && s_ready`. Pop: `state==SEND && !empty`. Push and pop in the same cycle leave the count unchanged. A push when full is impossible, because `s_ready` is low.
- FSM states: IDLE, SEND, GAP. Reset state is IDLE.
- IDLE:
  - If `i_req && i_en`, go to SEND with `pix_cnt=0`.
  - Otherwise stay in IDLE. No pop occurs in IDLE.
- SEND:
  - Pop whenever the FIFO is non-empty. Empty cycles are bubbles; `o_valid` is low for those cycles.
  - Each pop increments `pix_cnt`.
  - The pop with `pix_cnt==LINE_LENGTH-1` goes to GAP with `gap_cnt=0` and advances `line_cnt`, wrapping from `LINE_NUM-1` to 0.
  - `i_req` and `i_en` are ignored in SEND; a started line always completes.
- GAP:
  - `gap_cnt` increments each cycle.
  - At `gap_cnt==REQ_SETTLE-1`, go to IDLE.
  - `i_req` is ignored in GAP.
- Output register, updated each cycle:
  - `o_valid` <= pop.
  - `o_data` <= FIFO head; it holds its value when there is no pop.
  - `o_sol` <= pop && `pix_cnt==0`.
  - `o_eol` <= pop && `pix_cnt==LINE_LENGTH-1`.
  - `o_eof` <= that same `o_eol` condition && `line_cnt==LINE_NUM-1`.
- Counter widths: `pix_cnt` is `$clog2(LINE_LENGTH)` bits, `line_cnt` is `$clog2(LINE_NUM)` bits, FIFO count is `$clog2(FIFO_DEPTH)+1` bits.
- Reset values: all outputs 0 except `s_ready`=1 (FIFO empty). Counters are 0 and the FIFO is empty.
- Reset mid-line: the partial line and FIFO contents are discarded. After reset release, emission restarts at line 0 of a new frame.

## Timing
- Latency from pop to output is 1 cycle. Pixel order matches `s_data` arrival order.
- The first pop occurs no earlier than 1 cycle after IDLE sees `i_req` high.
- Let the last pop of a line be at cycle p, so that pixel's `o_valid` is at p+1. Then:
  - GAP occupies cycles p+1 … p+REQ_SETTLE.
  - IDLE next samples `i_req` at cycle p+REQ_SETTLE+1.
- Why the gap is needed: the controller drops `o_req` 2 cycles after its buffers reach 3·`LINE_LENGTH`. `REQ_SETTLE` ≥ 2 guarantees `i_req` is observed only after that drop, so no 4th line is ever over-fed.
- With a full FIFO and no stall, a line is `LINE_LENGTH` consecutive `o_valid` cycles.
- `i_req` held high continuously gives line period `LINE_LENGTH+REQ_SETTLE+1` cycles.

## Test plan
- Single line, no stalls: LINE_LENGTH=8, FIFO pre-filled with 0..15, `i_req` pulsed high for 1 cycle in IDLE. Required: exactly 8 `o_valid` cycles with data 0..7; `o_sol` with 0; `o_eol` with 7; FSM returns to IDLE; remaining data 8..15 stays in the FIFO.
- Request drop mid-line: `i_req` low 2 cycles after the line starts. Required: all 8 pixels are still emitted and no further line starts.
- Stale request: `i_req` stays high for exactly 2 cycles after the last `o_valid`, then goes low. Required: no new line starts (REQ_SETTLE=2).
- Upstream bubbles: `s_valid` toggles 1/0. Required: `o_valid` has gaps; exactly LINE_LENGTH pixels are emitted in order; `s_ready` goes low only when the FIFO holds 16 entries.
- Frame wrap: LINE_LENGTH=4, LINE_NUM=3, continuous request. Required: `o_eof` with the 12th pixel; the next `o_sol` begins line 0.
- Reset mid-line: RST asserted after 3 of 8 pixels are emitted. Required: all outputs 0 and `s_ready`=1 immediately (asynchronous); the next line after release starts with fresh FIFO data and `o_sol`.
